mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 3, SRAM access wait states; legal range 1..15.
REQ-002 SHALL have parameter ADDR_BASE, default 1024, byte address mapped to SRAM word 0.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port mem_read  input  1  load request from the EX/MEM stage.
REQ-006 SHALL have port mem_write  input  1  store request from the EX/MEM stage.
REQ-007 SHALL have port address  input  32  byte address from ALU.
REQ-008 SHALL have port wdata  input  32  store data (Rm value).
REQ-009 SHALL have port ready  output  1  access complete; pipeline freeze = ~ready.
REQ-010 SHALL have port rdata  output  32  load data to WB stage.
REQ-011 SHALL have port sram_addr  output  18  SRAM word address.
REQ-012 SHALL have port sram_wdata  output  32  SRAM write data.
REQ-013 SHALL have port sram_rdata  input  32  SRAM read data.
REQ-014 SHALL have port sram_we_n  output  1  SRAM write enable, active-low.
REQ-015 SHALL have port sram_oe_n  output  1  SRAM output enable, active-low.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-017 IDLE: mem_write=1 or mem_read=1 SHALL latch address, wdata and operation, load the wait counter with 0, and go to ACCESS next cycle.
REQ-018 mem_read and mem_write both 1 SHALL be treated as a write; the read is ignored.
REQ-019 ACCESS SHALL drive sram_addr = ((latched address - ADDR_BASE) >> 2)[17:0] and sram_wdata = latched wdata.
REQ-020 ACCESS SHALL hold sram_we_n=0 for writes and sram_oe_n=0 for reads for every ACCESS cycle; both SHALL be 1 in IDLE and DONE.
REQ-021 ACCESS SHALL increment the counter each cycle; when the counter equals WAIT_CYCLES-1, it SHALL go to DONE, and for reads SHALL register sram_rdata into rdata on that edge.
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE; a request present in that following IDLE cycle starts a new access.
REQ-023 ready SHALL be combinational: 1 when no request is present in IDLE, 1 in DONE, 0 otherwise.
REQ-024 Latency: a request first seen in IDLE at cycle 0 SHALL produce ready=1 at cycle WAIT_CYCLES+1, i.e. WAIT_CYCLES+1 freeze cycles.
REQ-025 A request deasserted during ACCESS (e.g. pipeline flush) SHALL NOT abort the access; the FSM SHALL complete through DONE and rdata SHALL update for reads.
REQ-026 Address and wdata changes during ACCESS SHALL NOT affect the SRAM access in progress.
REQ-027 rdata SHALL hold its last value across writes and idle cycles.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, counter 0, rdata 0, sram_we_n=1, sram_oe_n=1, sram_addr 0 and sram_wdata 0, including mid-access; an interrupted access SHALL NOT be retried.

Configuration
REQ-029 Macro MEM_RDBUF_EN SHALL, when defined, add a one-entry read buffer holding the last read word address, its data, and a valid bit.
REQ-030 With MEM_RDBUF_EN defined, a read in IDLE whose word address matches the valid buffer entry SHALL:
  - give ready=1 in the same cycle;
  - drive rdata = buffer data combinationally and register it;
  - start no SRAM access and leave the FSM in IDLE.
REQ-031 With MEM_RDBUF_EN defined, each completed SRAM read SHALL fill the buffer, any write SHALL clear valid, and reset SHALL clear valid.
REQ-032 Without MEM_RDBUF_EN, every read SHALL take the full SRAM access path and no buffer logic SHALL exist.

Verification
REQ-033 WAIT_CYCLES=3; store address=1028, wdata=0xDEADBEEF -> sram_addr=1, sram_we_n=0 for 3 cycles, ready=0 for 4 cycles, then ready=1.
REQ-034 Load address=1028, sram_rdata=0xDEADBEEF -> sram_oe_n=0 for 3 cycles, ready=1 at cycle 4, rdata=0xDEADBEEF.
REQ-035 mem_read=mem_write=1, address=1032 -> write to sram_addr=2, sram_oe_n stays 1.
REQ-036 rst=1 pulsed in the 2nd ACCESS cycle -> sram_we_n=1 and state IDLE immediately, rdata=0, no DONE.
REQ-037 mem_read dropped after cycle 1 of a load -> access completes, ready=1 at cycle 4, rdata updated.
REQ-038 MEM_RDBUF_EN defined: load 1028, repeat load 1028 -> second load ready=1 in cycle 0, no oe_n pulse; insert a store to 1040 -> next load 1028 takes the full 4 cycles.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM-stage SRAM controller: fixed wait-state accesses with a pipeline freeze (ready).
// Define MEM_RDBUF_EN to add a one-entry read buffer that returns repeat loads without an SRAM access.
module mem_stage_ctrl #(
    parameter int WAIT_CYCLES = 3,
    parameter int ADDR_BASE   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic [17:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        sram_we_n,
    output logic        sram_oe_n
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        op_write;
    logic [31:0] rdata_q;
    logic [17:0] word_addr;
    logic        req, start, last_wait, buf_hit;

    assign req       = mem_read | mem_write;
    assign word_addr = 18'((address - 32'(ADDR_BASE)) >> 2);
    assign last_wait = (cnt == 4'(WAIT_CYCLES - 1));
    assign start     = (state == IDLE) && req && !buf_hit;

`ifdef MEM_RDBUF_EN
    logic        buf_valid;
    logic [17:0] buf_addr;
    logic [31:0] buf_data;

    // Pure loads only; a read+write pair is a store and must reach the SRAM.
    assign buf_hit = (state == IDLE) && mem_read && !mem_write && buf_valid && (word_addr == buf_addr);
    assign rdata   = buf_hit ? buf_data : rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (start && mem_write) begin
            buf_valid <= 1'b0;
        end else if (state == ACCESS && last_wait && !op_write) begin
            buf_valid <= 1'b1;
            buf_addr  <= sram_addr;
            buf_data  <= sram_rdata;
        end
    end
`else
    assign buf_hit = 1'b0;
    assign rdata   = rdata_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCESS;
            ACCESS:  if (last_wait) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready     = ((state == IDLE) && (!req || buf_hit)) || (state == DONE);
        sram_we_n = !((state == ACCESS) && op_write);
        sram_oe_n = !((state == ACCESS) && !op_write);
    end

    // SRAM address/data are captured at request time so the pipeline may move them during ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            op_write   <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            rdata_q    <= '0;
        end else begin
            if (start) begin
                cnt        <= '0;
                op_write   <= mem_write;
                sram_addr  <= word_addr;
                sram_wdata <= wdata;
            end
            if (buf_hit) rdata_q <= rdata;
            if (state == ACCESS) begin
                cnt <= cnt + 4'd1;
                if (last_wait && !op_write) rdata_q <= sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl (WAIT_CYCLES=3, ADDR_BASE=1024); buffer scenario built with MEM_RDBUF_EN.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] address = '0, wdata = '0, sram_rdata = '0;
    logic        ready, sram_we_n, sram_oe_n;
    logic [31:0] rdata, sram_wdata;
    logic [17:0] sram_addr;
    int          checks = 0, errors = 0;

    mem_stage_ctrl #(.WAIT_CYCLES(3), .ADDR_BASE(1024)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .wdata(wdata), .ready(ready), .rdata(rdata),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        #1;
        checks++;
        if ({ready, sram_we_n, sram_oe_n} !== 3'b111) begin
            errors++; $display("FAIL reset_ctl: got %b expected 111", {ready, sram_we_n, sram_oe_n});
        end
        checks++;
        if (rdata !== 32'h0 || sram_addr !== 18'h0 || sram_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h expected zeros", rdata, sram_addr, sram_wdata);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_store();
        logic [2:0] exp;
        mem_write = 1'b1; address = 32'd1028; wdata = 32'hDEADBEEF;
        for (int c = 0; c < 5; c++) begin
            #1;
            exp = (c == 4) ? 3'b111 : (c == 0) ? 3'b011 : 3'b001;
            checks++;
            if ({ready, sram_we_n, sram_oe_n} !== exp) begin
                errors++; $display("FAIL store_c%0d: got %b expected %b", c, {ready, sram_we_n, sram_oe_n}, exp);
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if (sram_addr !== 18'd1 || sram_wdata !== 32'hDEADBEEF) begin
                    errors++; $display("FAIL store_bus_c%0d: got addr=%h data=%h expected 1/deadbeef", c, sram_addr, sram_wdata);
                end
            end
            tick();
        end
        mem_write = 1'b0;
        #1;
        checks++;
        if ({ready, sram_we_n} !== 2'b11) begin
            errors++; $display("FAIL store_idle: got %b expected 11", {ready, sram_we_n});
        end
        tick();
    endtask

    task automatic test_load();
        logic [2:0] exp;
        mem_read = 1'b1; address = 32'd1028; sram_rdata = 32'hDEADBEEF;
        for (int c = 0; c < 5; c++) begin
            #1;
            exp = (c == 4) ? 3'b111 : (c == 0) ? 3'b011 : 3'b010;
            checks++;
            if ({ready, sram_we_n, sram_oe_n} !== exp) begin
                errors++; $display("FAIL load_c%0d: got %b expected %b", c, {ready, sram_we_n, sram_oe_n}, exp);
            end
            if (c == 1) begin
                checks++;
                if (sram_addr !== 18'd1) begin
                    errors++; $display("FAIL load_addr: got %h expected 1", sram_addr);
                end
            end
            tick();
        end
        mem_read = 1'b0; sram_rdata = 32'h0;
        #1;
        checks++;
        if (rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_rdata: got %h expected deadbeef", rdata);
        end
        tick();
    endtask

    task automatic test_rw_both();
        logic [2:0] exp;
        mem_read = 1'b1; mem_write = 1'b1; address = 32'd1032; wdata = 32'h0BADF00D;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                address = 32'd2000; wdata = 32'h0;
            end
            #1;
            exp = (c == 4) ? 3'b111 : (c == 0) ? 3'b011 : 3'b001;
            checks++;
            if ({ready, sram_we_n, sram_oe_n} !== exp) begin
                errors++; $display("FAIL rw_c%0d: got %b expected %b", c, {ready, sram_we_n, sram_oe_n}, exp);
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if (sram_addr !== 18'd2 || sram_wdata !== 32'h0BADF00D) begin
                    errors++; $display("FAIL rw_bus_c%0d: got addr=%h data=%h expected 2/0badf00d", c, sram_addr, sram_wdata);
                end
            end
            tick();
        end
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        checks++;
        if (rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rw_rdata_hold: got %h expected deadbeef", rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp;
        mem_write = 1'b1; address = 32'd1028; wdata = 32'h1;
        for (int c = 0; c < 10; c++) begin
            if (c == 6) mem_write = 1'b0;
            #1;
            case (c)
                0, 5:    exp = 3'b011;
                4, 9:    exp = 3'b111;
                default: exp = 3'b001;
            endcase
            checks++;
            if ({ready, sram_we_n, sram_oe_n} !== exp) begin
                errors++; $display("FAIL b2b_c%0d: got %b expected %b", c, {ready, sram_we_n, sram_oe_n}, exp);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        mem_write = 1'b1; address = 32'd1028; wdata = 32'h5;
        tick();
        tick();
        mem_write = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if ({ready, sram_we_n, sram_oe_n} !== 3'b111) begin
            errors++; $display("FAIL rstmid_ctl: got %b expected 111", {ready, sram_we_n, sram_oe_n});
        end
        checks++;
        if (rdata !== 32'h0 || sram_addr !== 18'h0 || sram_wdata !== 32'h0) begin
            errors++; $display("FAIL rstmid_data: got rdata=%h addr=%h wdata=%h expected zeros", rdata, sram_addr, sram_wdata);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({ready, sram_we_n, sram_oe_n} !== 3'b111) begin
                errors++; $display("FAIL rstmid_noretry_c%0d: got %b expected 111", c, {ready, sram_we_n, sram_oe_n});
            end
            tick();
        end
    endtask

    task automatic test_flush();
        logic [2:0] exp;
        mem_read = 1'b1; address = 32'd1036; sram_rdata = 32'h12345678;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) mem_read = 1'b0;
            #1;
            exp = (c == 4) ? 3'b111 : (c == 0) ? 3'b011 : 3'b010;
            checks++;
            if ({ready, sram_we_n, sram_oe_n} !== exp) begin
                errors++; $display("FAIL flush_c%0d: got %b expected %b", c, {ready, sram_we_n, sram_oe_n}, exp);
            end
            if (c == 1) begin
                checks++;
                if (sram_addr !== 18'd3) begin
                    errors++; $display("FAIL flush_addr: got %h expected 3", sram_addr);
                end
            end
            if (c == 4) begin
                checks++;
                if (rdata !== 32'h12345678) begin
                    errors++; $display("FAIL flush_rdata: got %h expected 12345678", rdata);
                end
            end
            tick();
        end
    endtask

`ifdef MEM_RDBUF_EN
    task automatic full_load(input logic [31:0] data, input string tag);
        logic [2:0] exp;
        mem_read = 1'b1; address = 32'd1028; sram_rdata = data;
        for (int c = 0; c < 5; c++) begin
            #1;
            exp = (c == 4) ? 3'b111 : (c == 0) ? 3'b011 : 3'b010;
            checks++;
            if ({ready, sram_we_n, sram_oe_n} !== exp) begin
                errors++; $display("FAIL %s_c%0d: got %b expected %b", tag, c, {ready, sram_we_n, sram_oe_n}, exp);
            end
            if (c == 4) begin
                checks++;
                if (rdata !== data) begin
                    errors++; $display("FAIL %s_rdata: got %h expected %h", tag, rdata, data);
                end
            end
            tick();
        end
    endtask

    task automatic test_rdbuf();
        full_load(32'hAAAA5555, "buf_miss");
        sram_rdata = 32'h0;
        #1;
        checks++;
        if ({ready, sram_oe_n} !== 2'b11 || rdata !== 32'hAAAA5555) begin
            errors++; $display("FAIL buf_hit: got ready/oe=%b rdata=%h expected 11/aaaa5555", {ready, sram_oe_n}, rdata);
        end
        tick();
        mem_read = 1'b0;
        #1;
        checks++;
        if ({ready, sram_oe_n} !== 2'b11 || rdata !== 32'hAAAA5555) begin
            errors++; $display("FAIL buf_hit_reg: got ready/oe=%b rdata=%h expected 11/aaaa5555", {ready, sram_oe_n}, rdata);
        end
        tick();
        mem_write = 1'b1; address = 32'd1040; wdata = 32'h77;
        for (int c = 0; c < 5; c++) tick();
        mem_write = 1'b0;
        tick();
        full_load(32'h11112222, "buf_inval");
        mem_read = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_store();
        test_load();
        test_rw_both();
        test_back_to_back();
        test_reset_mid();
        test_flush();
`ifdef MEM_RDBUF_EN
        test_rdbuf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
